fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch stage for the RV64IMFD pipeline. It sits between the PC source and decode. It holds the architectural fetch PC and predicts next-PC with an internal direct-mapped BTB. It issues pipelined requests to instruction memory and reorders nothing: responses return in order into a fetch queue that feeds decode through a ready/valid handshake. Branch/jump redirects from execute flush the queue and discard stale in-flight responses.

## Interface
- PC_W, 48, fetch address width
- INSTR_W, 32, instruction width
- FQ_DEPTH, 4, fetch-queue entries (power of 2, ≥2); also the in-flight request cap
- BTB_ENTRIES, 16, BTB entries (power of 2)
- RESET_PC, '0, PC loaded on reset
- clk  in  1  clock
- n_reset  in  1  asynchronous, active-low reset
- redirect  in  1  mispredict/redirect from execute
- redirect_pc  in  PC_W  correct PC
- upd_valid  in  1  BTB update strobe
- upd_pc  in  PC_W  PC of the resolved branch
- upd_target  in  PC_W  resolved target
- upd_taken  in  1  resolved direction
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  request address (= pc)
- imem_rsp_valid  in  1  in-order response, always accepted
- imem_rsp_data  in  INSTR_W  instruction
- out_valid  out  1  instruction to decode
- out_ready  in  1  decode accepts
- out_pc  out  PC_W  PC of out_instr
- out_instr  out  INSTR_W  instruction
- out_pred_taken  out  1  BTB hit was used for this instruction

## Operation
- Reset: pc=RESET_PC; FQ empty; in_flight=0; drop_cnt=0; all BTB valid bits 0; imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0, out_pred_taken=0.
- BTB: index = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[PC_W-1:log2(BTB_ENTRIES)+2]; entry = {valid, tag, target}. Hit = valid && tag match.
- Issue: imem_req_valid = !redirect && FQ not full (allocated < FQ_DEPTH) && in_flight < FQ_DEPTH. Handshake fires on imem_req_valid && imem_req_ready. On fire, allocate the FQ tail entry {pc, pred=hit, filled=0}. Also set pc <= hit ? target : pc+4 (PC_W modulo wrap).
- Response: if drop_cnt>0, discard the response and decrement drop_cnt. Otherwise write instr into the oldest unfilled entry and set filled=1. in_flight = issued − responded, counting dropped responses.
- Output: out_valid = head.filled && !redirect; out_* reflect the head. Pop on out_valid && out_ready.
- Redirect (highest priority): pc <= redirect_pc; FQ cleared; no issue and no pop that cycle. drop_cnt <= in_flight − (imem_rsp_valid ? 1 : 0), so a response in the redirect cycle counts as dropped.
- BTB update on upd_valid: upd_taken=1 writes {1, tag(upd_pc), upd_target}. upd_taken=0 clears valid only on a tag match. The update may coincide with redirect.
- Simultaneous issue + response + pop in one cycle is legal; occupancy adjusts by the net change.

## Timing
- Request address is pc register output (combinational valid gating only); next-PC takes effect the cycle after fire.
- Memory latency ≥1 cycle, unbounded; sustained throughput 1 instr/cycle once the latency is covered by FQ_DEPTH.
- Response to out_valid: 1 cycle (fill registered, head visible next cycle).
- Redirect to first new request: imem_req_valid high the cycle after redirect, with addr = redirect_pc.
- BTB update becomes visible to lookups the cycle after upd_valid. A same-cycle lookup sees old contents.
- Reset mid-operation clears all state immediately. Responses arriving after reset release are not dropped, so the memory side must be reset together with this block.
- Back-pressure: FQ full or in_flight==FQ_DEPTH holds imem_req_valid low and pc stable. out_ready low holds the head stable.

## Test plan
- Reset RESET_PC=0x1000, imem_req_ready=1, 1-cycle memory, out_ready=1 → out_pc sequence 0x1000,0x1004,0x1008…; one instr per cycle after fill.
- BTB update upd_pc=0x1008, target=0x2000, taken, then redirect to 0x1000 → fetch order 0x1000,0x1004,0x1008,0x2000; 0x1008 has out_pred_taken=1.
- 3-cycle memory latency with 3 requests in flight, redirect to 0x4000 → the 3 old responses are discarded; first out_pc=0x4000 with its matching instr.
- out_ready=0 for 10 cycles with FQ_DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0 and pc stable. Release → in-order drain with no loss.
- Not-taken update on the 0x1008 entry, then re-fetch → 0x100C follows 0x1008 and pred=0. Not-taken update with a mismatching tag → entry unchanged.
- pc=0xFFFF_FFFF_FFFC (PC_W=48), no hit → next request addr 0x0 (wrap).

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: execute redirect/BTB update, imem request/response, decode handshake.
// master = fetch_unit side, slave = environment (execute, memory, decode).
interface fetch_unit_if #(
  parameter int PC_W    = 48,
  parameter int INSTR_W = 32
);
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               upd_valid;
  logic [PC_W-1:0]    upd_pc;
  logic [PC_W-1:0]    upd_target;
  logic               upd_taken;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_pred_taken;

  modport master (
    input  redirect, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
           imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, out_pred_taken
  );
  modport slave (
    output redirect, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
           imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, out_pred_taken
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, direct-mapped BTB next-PC prediction,
// pipelined in-order imem requests into a fetch queue feeding decode.
module fetch_unit #(
  parameter int              PC_W        = 48,
  parameter int              INSTR_W     = 32,
  parameter int              FQ_DEPTH    = 4,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input logic         clk,
  input logic         n_reset,
  fetch_unit_if.master bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               pred;
    logic               filled;
  } fq_ent_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  tgt;
  } btb_ent_t;

  logic [PC_W-1:0]               pc;
  logic                          run;
  fq_ent_t  [FQ_DEPTH-1:0]       fq;
  btb_ent_t [BTB_ENTRIES-1:0]    btb;
  logic [PTR_W-1:0]              head, tail, fill;
  logic [CNT_W-1:0]              count, in_flight, drop_cnt;

  logic [IDX_W-1:0] idx, upd_idx;
  logic [TAG_W-1:0] tag, upd_tag;
  logic             hit, req_valid, fire, out_valid, pop;
  logic             unused_upd_lsb;

  assign idx     = pc[IDX_W+1:2];
  assign tag     = pc[PC_W-1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[PC_W-1:IDX_W+2];
  assign unused_upd_lsb = ^bus.upd_pc[1:0];

  // run holds requests off while in reset and for the first edge after release
  always_comb begin
    hit       = btb[idx].vld && (btb[idx].tag == tag);
    req_valid = run && !bus.redirect && (count != CNT_W'(FQ_DEPTH)) &&
                (in_flight != CNT_W'(FQ_DEPTH));
    fire      = req_valid && bus.imem_req_ready;
    out_valid = fq[head].filled && !bus.redirect;
    pop       = out_valid && bus.out_ready;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = fq[head].pc;
  assign bus.out_instr      = fq[head].instr;
  assign bus.out_pred_taken = fq[head].pred;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc        <= RESET_PC;
      run       <= 1'b0;
      fq        <= '0;
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      count     <= '0;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      run       <= 1'b1;
      in_flight <= in_flight + CNT_W'(fire) - CNT_W'(bus.imem_rsp_valid);
      if (bus.redirect) begin
        // everything still in flight is stale; a response this cycle is one of them
        pc       <= bus.redirect_pc;
        head     <= '0;
        tail     <= '0;
        fill     <= '0;
        count    <= '0;
        drop_cnt <= in_flight - CNT_W'(bus.imem_rsp_valid);
        for (int i = 0; i < FQ_DEPTH; i++) fq[i].filled <= 1'b0;
      end else begin
        if (fire) begin
          pc       <= hit ? btb[idx].tgt : pc + PC_W'(4);
          fq[tail] <= '{pc: pc, instr: '0, pred: hit, filled: 1'b0};
          tail     <= tail + 1'b1;
        end
        if (bus.imem_rsp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - 1'b1;
          end else begin
            fq[fill].instr  <= bus.imem_rsp_data;
            fq[fill].filled <= 1'b1;
            fill            <= fill + 1'b1;
          end
        end
        if (pop) begin
          fq[head].filled <= 1'b0;
          head            <= head + 1'b1;
        end
        count <= count + CNT_W'(fire) - CNT_W'(pop);
      end
    end
  end

  // same-cycle lookups see the old entry; writes land at the edge
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      btb <= '0;
    end else if (bus.upd_valid) begin
      if (bus.upd_taken)
        btb[upd_idx] <= '{vld: 1'b1, tag: upd_tag, tgt: bus.upd_target};
      else if (btb[upd_idx].tag == upd_tag)
        btb[upd_idx].vld <= 1'b0;
    end
  end
endmodule
